// File: rtl/ysyx_23060025_axi_xbar.sv
// One-master, two-slave AXI4 crossbar.
//   Slave 0: SoC bus (default target).  Slave 1: CLINT (read-only).
// Each address is decoded once, at acceptance; the route stays locked until the burst completes.
// Writes that hit the CLINT are never forwarded: the data beats are sunk and SLVERR is returned.
// Ports:
//   clock, reset       - clock and asynchronous active-low reset
//   m_ar*/m_r*         - master read address / read data channels
//   m_aw*/m_w*/m_b*    - master write address / write data / write response channels
//   s0_*, s1_*         - slave-side channels (slave 1 has read channels only)
//   rd_busy, wr_busy   - read / write FSM not idle
module ysyx_23060025_axi_xbar #(
    parameter int unsigned         ADDR_LEN   = 32,
    parameter int unsigned         DATA_LEN   = 32,
    parameter logic [ADDR_LEN-1:0] CLINT_BASE = 32'h0200_0000,
    parameter logic [ADDR_LEN-1:0] CLINT_MASK = 32'hffff_0000
) (
    input  logic                  clock,
    input  logic                  reset,
    // master read
    input  logic [ADDR_LEN-1:0]   m_araddr,
    input  logic [7:0]            m_arlen,
    input  logic [2:0]            m_arsize,
    input  logic                  m_arvalid,
    output logic                  m_arready,
    output logic [DATA_LEN-1:0]   m_rdata,
    output logic [1:0]            m_rresp,
    output logic                  m_rlast,
    output logic                  m_rvalid,
    input  logic                  m_rready,
    // master write
    input  logic [ADDR_LEN-1:0]   m_awaddr,
    input  logic [7:0]            m_awlen,
    input  logic [2:0]            m_awsize,
    input  logic                  m_awvalid,
    output logic                  m_awready,
    input  logic [DATA_LEN-1:0]   m_wdata,
    input  logic [DATA_LEN/8-1:0] m_wstrb,
    input  logic                  m_wlast,
    input  logic                  m_wvalid,
    output logic                  m_wready,
    output logic [1:0]            m_bresp,
    output logic                  m_bvalid,
    input  logic                  m_bready,
    // slave 0 read
    output logic [ADDR_LEN-1:0]   s0_araddr,
    output logic [7:0]            s0_arlen,
    output logic [2:0]            s0_arsize,
    output logic                  s0_arvalid,
    input  logic                  s0_arready,
    input  logic [DATA_LEN-1:0]   s0_rdata,
    input  logic [1:0]            s0_rresp,
    input  logic                  s0_rlast,
    input  logic                  s0_rvalid,
    output logic                  s0_rready,
    // slave 1 read
    output logic [ADDR_LEN-1:0]   s1_araddr,
    output logic [7:0]            s1_arlen,
    output logic [2:0]            s1_arsize,
    output logic                  s1_arvalid,
    input  logic                  s1_arready,
    input  logic [DATA_LEN-1:0]   s1_rdata,
    input  logic [1:0]            s1_rresp,
    input  logic                  s1_rlast,
    input  logic                  s1_rvalid,
    output logic                  s1_rready,
    // slave 0 write
    output logic [ADDR_LEN-1:0]   s0_awaddr,
    output logic [7:0]            s0_awlen,
    output logic [2:0]            s0_awsize,
    output logic                  s0_awvalid,
    input  logic                  s0_awready,
    output logic [DATA_LEN-1:0]   s0_wdata,
    output logic [DATA_LEN/8-1:0] s0_wstrb,
    output logic                  s0_wlast,
    output logic                  s0_wvalid,
    input  logic                  s0_wready,
    input  logic [1:0]            s0_bresp,
    input  logic                  s0_bvalid,
    output logic                  s0_bready,
    // status
    output logic                  rd_busy,
    output logic                  wr_busy
);

    typedef enum logic [1:0] {RIdle, RAddr, RData} rstate_e;
    typedef enum logic [2:0] {WIdle, WAddr, WData, WResp, WEData, WEResp} wstate_e;

    rstate_e rstate_q, rstate_d;
    wstate_e wstate_q, wstate_d;

    logic                rst_done_q;
    logic [ADDR_LEN-1:0] ar_addr_q, aw_addr_q;
    logic [7:0]          ar_len_q, aw_len_q;
    logic [2:0]          ar_size_q, aw_size_q;
    logic                ar_tgt_q;  // 1: CLINT

    logic ar_fire, aw_fire, ar_hit, aw_hit;

    assign ar_hit  = (m_araddr & CLINT_MASK) == CLINT_BASE;
    assign aw_hit  = (m_awaddr & CLINT_MASK) == CLINT_BASE;
    assign ar_fire = m_arvalid & m_arready;
    assign aw_fire = m_awvalid & m_awready;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rst_done_q <= 1'b0;
            rstate_q   <= RIdle;
            wstate_q   <= WIdle;
            ar_addr_q  <= '0;
            ar_len_q   <= '0;
            ar_size_q  <= '0;
            ar_tgt_q   <= 1'b0;
            aw_addr_q  <= '0;
            aw_len_q   <= '0;
            aw_size_q  <= '0;
        end else begin
            rst_done_q <= 1'b1;
            rstate_q   <= rstate_d;
            wstate_q   <= wstate_d;
            if (ar_fire) begin
                ar_addr_q <= m_araddr;
                ar_len_q  <= m_arlen;
                ar_size_q <= m_arsize;
                ar_tgt_q  <= ar_hit;
            end
            if (aw_fire) begin
                aw_addr_q <= m_awaddr;
                aw_len_q  <= m_awlen;
                aw_size_q <= m_awsize;
            end
        end
    end

    // AR fields are broadcast; only the selected slave sees arvalid.
    assign s0_araddr = ar_addr_q;
    assign s0_arlen  = ar_len_q;
    assign s0_arsize = ar_size_q;
    assign s1_araddr = ar_addr_q;
    assign s1_arlen  = ar_len_q;
    assign s1_arsize = ar_size_q;
    assign s0_awaddr = aw_addr_q;
    assign s0_awlen  = aw_len_q;
    assign s0_awsize = aw_size_q;

    assign rd_busy = rstate_q != RIdle;
    assign wr_busy = wstate_q != WIdle;

    // Read path
    always_comb begin
        rstate_d   = rstate_q;
        m_arready  = rst_done_q & (rstate_q == RIdle);
        s0_arvalid = 1'b0;
        s1_arvalid = 1'b0;
        s0_rready  = 1'b0;
        s1_rready  = 1'b0;
        m_rdata    = '0;
        m_rresp    = '0;
        m_rlast    = 1'b0;
        m_rvalid   = 1'b0;
        unique case (rstate_q)
            RIdle: if (ar_fire) rstate_d = RAddr;
            RAddr: begin
                if (ar_tgt_q) begin
                    s1_arvalid = 1'b1;
                    if (s1_arready) rstate_d = RData;
                end else begin
                    s0_arvalid = 1'b1;
                    if (s0_arready) rstate_d = RData;
                end
            end
            RData: begin
                if (ar_tgt_q) begin
                    m_rdata   = s1_rdata;
                    m_rresp   = s1_rresp;
                    m_rlast   = s1_rlast;
                    m_rvalid  = s1_rvalid;
                    s1_rready = m_rready;
                    if (s1_rvalid && m_rready && s1_rlast) rstate_d = RIdle;
                end else begin
                    m_rdata   = s0_rdata;
                    m_rresp   = s0_rresp;
                    m_rlast   = s0_rlast;
                    m_rvalid  = s0_rvalid;
                    s0_rready = m_rready;
                    if (s0_rvalid && m_rready && s0_rlast) rstate_d = RIdle;
                end
            end
            default: rstate_d = RIdle;
        endcase
    end

    // Write path; CLINT writes are absorbed locally in WEData/WEResp.
    always_comb begin
        wstate_d   = wstate_q;
        m_awready  = rst_done_q & (wstate_q == WIdle);
        s0_awvalid = 1'b0;
        s0_wdata   = '0;
        s0_wstrb   = '0;
        s0_wlast   = 1'b0;
        s0_wvalid  = 1'b0;
        s0_bready  = 1'b0;
        m_wready   = 1'b0;
        m_bresp    = '0;
        m_bvalid   = 1'b0;
        unique case (wstate_q)
            WIdle: if (aw_fire) wstate_d = aw_hit ? WEData : WAddr;
            WAddr: begin
                s0_awvalid = 1'b1;
                if (s0_awready) wstate_d = WData;
            end
            WData: begin
                s0_wdata  = m_wdata;
                s0_wstrb  = m_wstrb;
                s0_wlast  = m_wlast;
                s0_wvalid = m_wvalid;
                m_wready  = s0_wready;
                if (m_wvalid && s0_wready && m_wlast) wstate_d = WResp;
            end
            WResp: begin
                m_bvalid  = s0_bvalid;
                m_bresp   = s0_bresp;
                s0_bready = m_bready;
                if (s0_bvalid && m_bready) wstate_d = WIdle;
            end
            WEData: begin
                m_wready = 1'b1;
                if (m_wvalid && m_wlast) wstate_d = WEResp;
            end
            WEResp: begin
                m_bvalid = 1'b1;
                m_bresp  = 2'b10;
                if (m_bready) wstate_d = WIdle;
            end
            default: wstate_d = WIdle;
        endcase
    end

endmodule

// File: tb/tb_ysyx_23060025_axi_xbar.sv
// Self-checking bench for ysyx_23060025_axi_xbar: directed table, hand-written corner
// sequences (concurrency, reset mid-burst) and randomized bursts against a routing model.
module tb_ysyx_23060025_axi_xbar;

    logic        clock, reset;
    logic [31:0] m_araddr, m_awaddr, m_rdata, m_wdata;
    logic [7:0]  m_arlen, m_awlen;
    logic [2:0]  m_arsize, m_awsize;
    logic        m_arvalid, m_arready, m_rlast, m_rvalid, m_rready;
    logic [1:0]  m_rresp, m_bresp;
    logic        m_awvalid, m_awready, m_wlast, m_wvalid, m_wready, m_bvalid, m_bready;
    logic [3:0]  m_wstrb, s0_wstrb;
    logic [31:0] s0_araddr, s1_araddr, s0_rdata, s1_rdata, s0_awaddr, s0_wdata;
    logic [7:0]  s0_arlen, s1_arlen, s0_awlen;
    logic [2:0]  s0_arsize, s1_arsize, s0_awsize;
    logic        s0_arvalid, s0_arready, s1_arvalid, s1_arready;
    logic [1:0]  s0_rresp, s1_rresp, s0_bresp;
    logic        s0_rlast, s0_rvalid, s0_rready, s1_rlast, s1_rvalid, s1_rready;
    logic        s0_awvalid, s0_awready, s0_wlast, s0_wvalid, s0_wready;
    logic        s0_bvalid, s0_bready, rd_busy, wr_busy;

    int n_checks = 0;
    int n_fail   = 0;

    ysyx_23060025_axi_xbar dut (
        .clock(clock), .reset(reset),
        .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
        .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast), .m_rvalid(m_rvalid),
        .m_rready(m_rready),
        .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize),
        .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid),
        .m_wready(m_wready), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .s0_araddr(s0_araddr), .s0_arlen(s0_arlen), .s0_arsize(s0_arsize),
        .s0_arvalid(s0_arvalid), .s0_arready(s0_arready),
        .s0_rdata(s0_rdata), .s0_rresp(s0_rresp), .s0_rlast(s0_rlast), .s0_rvalid(s0_rvalid),
        .s0_rready(s0_rready),
        .s1_araddr(s1_araddr), .s1_arlen(s1_arlen), .s1_arsize(s1_arsize),
        .s1_arvalid(s1_arvalid), .s1_arready(s1_arready),
        .s1_rdata(s1_rdata), .s1_rresp(s1_rresp), .s1_rlast(s1_rlast), .s1_rvalid(s1_rvalid),
        .s1_rready(s1_rready),
        .s0_awaddr(s0_awaddr), .s0_awlen(s0_awlen), .s0_awsize(s0_awsize),
        .s0_awvalid(s0_awvalid), .s0_awready(s0_awready),
        .s0_wdata(s0_wdata), .s0_wstrb(s0_wstrb), .s0_wlast(s0_wlast), .s0_wvalid(s0_wvalid),
        .s0_wready(s0_wready), .s0_bresp(s0_bresp), .s0_bvalid(s0_bvalid),
        .s0_bready(s0_bready),
        .rd_busy(rd_busy), .wr_busy(wr_busy)
    );

    logic [221:0] all_out;
    assign all_out = {m_arready, m_rdata, m_rresp, m_rlast, m_rvalid, m_awready, m_wready,
                      m_bresp, m_bvalid, s0_araddr, s0_arlen, s0_arsize, s0_arvalid, s0_rready,
                      s1_araddr, s1_arlen, s1_arsize, s1_arvalid, s1_rready, s0_awaddr,
                      s0_awlen, s0_awsize, s0_awvalid, s0_wdata, s0_wstrb, s0_wlast, s0_wvalid,
                      s0_bready, rd_busy, wr_busy};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Reference routing rule.
    function automatic bit clint_hit(input logic [31:0] a);
        return (a & 32'hffff_0000) == 32'h0200_0000;
    endfunction

    task automatic clear_inputs();
        m_araddr = '0; m_arlen = '0; m_arsize = '0; m_arvalid = 0; m_rready = 0;
        m_awaddr = '0; m_awlen = '0; m_awsize = '0; m_awvalid = 0;
        m_wdata = '0; m_wstrb = '0; m_wlast = 0; m_wvalid = 0; m_bready = 0;
        s0_arready = 0; s0_rdata = '0; s0_rresp = '0; s0_rlast = 0; s0_rvalid = 0;
        s1_arready = 0; s1_rdata = '0; s1_rresp = '0; s1_rlast = 0; s1_rvalid = 0;
        s0_awready = 0; s0_wready = 0; s0_bresp = '0; s0_bvalid = 0;
    endtask

    // Selected slave gets the real beat; the other slave is driven with a decoy beat.
    task automatic drive_r(input bit sel, input logic v, input logic [31:0] d,
                           input logic [1:0] rsp, input logic l);
        if (sel) begin
            s1_rvalid = v; s1_rdata = d; s1_rresp = rsp; s1_rlast = l;
            s0_rvalid = v; s0_rdata = ~d; s0_rresp = ~rsp; s0_rlast = ~l;
        end else begin
            s0_rvalid = v; s0_rdata = d; s0_rresp = rsp; s0_rlast = l;
            s1_rvalid = v; s1_rdata = ~d; s1_rresp = ~rsp; s1_rlast = ~l;
        end
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input int stall,
                           input bit exp_clint, input logic [31:0] dbase,
                           input logic [31:0] dinc);
        logic [1:0] rsp;
        logic [31:0] d;
        m_araddr = addr; m_arlen = len; m_arsize = 3'd2; m_arvalid = 1; m_rready = 1;
        #1 check("ar_accept", 64'(m_arready), 64'd1);
        tick();
        m_arvalid = 0; m_araddr = 32'hdead_0000; m_arlen = 8'hff;
        #1;
        check("rd_busy_set", 64'(rd_busy), 64'd1);
        check("ar_valid_sel", 64'(exp_clint ? s1_arvalid : s0_arvalid), 64'd1);
        check("ar_valid_other", 64'(exp_clint ? s0_arvalid : s1_arvalid), 64'd0);
        check("ar_addr", 64'(exp_clint ? s1_araddr : s0_araddr), 64'(addr));
        check("ar_len", 64'(exp_clint ? s1_arlen : s0_arlen), 64'(len));
        for (int k = 0; k < stall; k++) begin
            s0_arready = exp_clint; s1_arready = !exp_clint;
            m_arvalid = 1; m_araddr = addr ^ 32'h40;
            tick();
            check("ar_stall_valid", 64'(exp_clint ? s1_arvalid : s0_arvalid), 64'd1);
            check("ar_stall_addr", 64'(exp_clint ? s1_araddr : s0_araddr), 64'(addr));
            check("ar_stall_len", 64'(exp_clint ? s1_arlen : s0_arlen), 64'(len));
            check("ar_stall_mready", 64'(m_arready), 64'd0);
        end
        m_arvalid = 0;
        s0_arready = !exp_clint; s1_arready = exp_clint;
        tick();
        s0_arready = 0; s1_arready = 0;
        for (int b = 0; b <= int'(len); b++) begin
            rsp = 2'($urandom_range(0, 3));
            d = dbase + dinc * b;
            drive_r(exp_clint, 1'b1, d, rsp, 1'(b == int'(len)));
            #1;
            check("r_valid", 64'(m_rvalid), 64'd1);
            check("r_data", 64'(m_rdata), 64'(d));
            check("r_resp", 64'(m_rresp), 64'(rsp));
            check("r_last", 64'(m_rlast), 64'(b == int'(len)));
            check("r_ready_sel", 64'(exp_clint ? s1_rready : s0_rready), 64'd1);
            check("r_ready_other", 64'(exp_clint ? s0_rready : s1_rready), 64'd0);
            tick();
        end
        drive_r(exp_clint, 1'b0, '0, '0, 1'b0);
        m_rready = 0;
        #1;
        check("rd_idle", 64'(rd_busy), 64'd0);
        check("ar_ready_back", 64'(m_arready), 64'd1);
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input int stall,
                            input bit exp_err, input logic [31:0] dbase,
                            input logic [31:0] dinc);
        logic [1:0] rsp;
        logic [31:0] d;
        // W data ahead of AW must be stalled.
        m_wvalid = 1; m_wdata = dbase; m_wstrb = 4'hf; m_wlast = (len == 0);
        #1 check("w_early_stall", 64'(m_wready), 64'd0);
        m_awaddr = addr; m_awlen = len; m_awsize = 3'd2; m_awvalid = 1;
        #1 check("aw_accept", 64'(m_awready), 64'd1);
        tick();
        m_awvalid = 0; m_awaddr = 32'hbeef_0000;
        #1;
        check("wr_busy_set", 64'(wr_busy), 64'd1);
        check("aw_valid", 64'(s0_awvalid), 64'(!exp_err));
        if (!exp_err) begin
            check("aw_addr", 64'(s0_awaddr), 64'(addr));
            check("aw_len", 64'(s0_awlen), 64'(len));
            check("w_stall_addr_phase", 64'(m_wready), 64'd0);
            for (int k = 0; k < stall; k++) begin
                tick();
                check("aw_stall_valid", 64'(s0_awvalid), 64'd1);
                check("aw_stall_addr", 64'(s0_awaddr), 64'(addr));
                check("aw_stall_mready", 64'(m_awready), 64'd0);
            end
            s0_awready = 1;
            tick();
            s0_awready = 0;
        end
        for (int b = 0; b <= int'(len); b++) begin
            d = dbase + dinc * b;
            m_wvalid = 1; m_wdata = d; m_wstrb = 4'(b + 1); m_wlast = (b == int'(len));
            s0_wready = !exp_err;
            #1;
            check("w_ready", 64'(m_wready), 64'd1);
            check("w_fwd_valid", 64'(s0_wvalid), 64'(!exp_err));
            if (!exp_err) begin
                check("w_fwd_data", 64'(s0_wdata), 64'(d));
                check("w_fwd_strb", 64'(s0_wstrb), 64'(b + 1));
                check("w_fwd_last", 64'(s0_wlast), 64'(b == int'(len)));
            end
            tick();
        end
        m_wvalid = 0; m_wlast = 0; s0_wready = 0;
        rsp = exp_err ? 2'b10 : 2'($urandom_range(0, 3));
        s0_bvalid = !exp_err; s0_bresp = exp_err ? 2'b00 : rsp;
        m_bready = 0;
        #1;
        check("b_valid", 64'(m_bvalid), 64'd1);
        check("b_resp", 64'(m_bresp), 64'(rsp));
        tick();
        check("b_hold", 64'(m_bvalid), 64'd1);
        m_bready = 1;
        #1 check("b_ready_fwd", 64'(s0_bready), 64'(!exp_err));
        tick();
        m_bready = 0; s0_bvalid = 0;
        #1;
        check("wr_idle", 64'(wr_busy), 64'd0);
        check("aw_ready_back", 64'(m_awready), 64'd1);
    endtask

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [7:0]  len;
        int          stall;
        bit          exp_clint;
        logic [31:0] dbase;
        logic [31:0] dinc;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{0, 32'h8000_0000, 8'd3, 0, 0, 32'h11, 32'h11};
        vecs[1] = '{0, 32'h0200_bff8, 8'd0, 0, 1, 32'h1234_5678, 32'h0};
        vecs[2] = '{1, 32'h0200_4000, 8'd1, 0, 1, 32'ha, 32'h1};
        vecs[3] = '{0, 32'h8000_0000, 8'd1, 5, 0, 32'hcafe_0000, 32'h4};
        vecs[4] = '{0, 32'h0201_0000, 8'd0, 1, 0, 32'h5555_0000, 32'h0};
        vecs[5] = '{0, 32'h01ff_fffc, 8'd0, 0, 0, 32'h6666_0000, 32'h0};
        vecs[6] = '{1, 32'h0200_fffc, 8'd0, 0, 1, 32'h7, 32'h0};
        vecs[7] = '{1, 32'h8000_0100, 8'd2, 3, 0, 32'hdead_beef, 32'h10};

        // Reset: every output 0 even with inputs active.
        clear_inputs();
        reset = 0;
        m_arvalid = 1; m_awvalid = 1; m_wvalid = 1; s0_rvalid = 1; s0_rdata = 32'hffff_ffff;
        s0_bvalid = 1; m_rready = 1; m_bready = 1;
        #23;
        check("reset_outputs_zero", 64'(|all_out), 64'd0);
        clear_inputs();
        @(negedge clock);
        reset = 1;
        #1;
        check("arready_pre_rst_done", 64'(m_arready), 64'd0);
        check("awready_pre_rst_done", 64'(m_awready), 64'd0);
        tick();
        check("arready_after_rst_done", 64'(m_arready), 64'd1);
        check("awready_after_rst_done", 64'(m_awready), 64'd1);

        // Directed table.
        foreach (vecs[i]) begin
            if (vecs[i].wr)
                do_write(vecs[i].addr, vecs[i].len, vecs[i].stall, vecs[i].exp_clint,
                         vecs[i].dbase, vecs[i].dinc);
            else
                do_read(vecs[i].addr, vecs[i].len, vecs[i].stall, vecs[i].exp_clint,
                        vecs[i].dbase, vecs[i].dinc);
        end

        // Concurrent read to CLINT and write to SoC bus.
        m_araddr = 32'h0200_0000; m_arlen = 0; m_arvalid = 1; m_rready = 1;
        m_awaddr = 32'h8000_0100; m_awlen = 0; m_awvalid = 1;
        #1;
        check("cc_arready", 64'(m_arready), 64'd1);
        check("cc_awready", 64'(m_awready), 64'd1);
        tick();
        m_arvalid = 0; m_awvalid = 0;
        #1;
        check("cc_busy_both", 64'({rd_busy, wr_busy}), 64'd3);
        check("cc_s1_arvalid", 64'(s1_arvalid), 64'd1);
        check("cc_s0_arvalid", 64'(s0_arvalid), 64'd0);
        check("cc_s0_awvalid", 64'(s0_awvalid), 64'd1);
        s1_arready = 1; s0_awready = 1;
        tick();
        s1_arready = 0; s0_awready = 0;
        drive_r(1'b1, 1'b1, 32'h0bad_f00d, 2'b00, 1'b1);
        m_wvalid = 1; m_wdata = 32'hdead_beef; m_wstrb = 4'hf; m_wlast = 1; s0_wready = 1;
        #1;
        check("cc_rdata", 64'(m_rdata), 64'h0bad_f00d);
        check("cc_wdata", 64'(s0_wdata), 64'hdead_beef);
        check("cc_wstrb", 64'(s0_wstrb), 64'hf);
        tick();
        drive_r(1'b1, 1'b0, '0, '0, 1'b0);
        m_wvalid = 0; m_wlast = 0; s0_wready = 0; m_rready = 0;
        s0_bvalid = 1; s0_bresp = 2'b01; m_bready = 1;
        #1;
        check("cc_rd_done", 64'(rd_busy), 64'd0);
        check("cc_bresp", 64'({m_bvalid, m_bresp}), 64'b101);
        tick();
        s0_bvalid = 0; m_bready = 0;
        #1 check("cc_wr_done", 64'(wr_busy), 64'd0);

        // Reset during beat 2 of a 4-beat read.
        m_araddr = 32'h8000_0040; m_arlen = 3; m_arvalid = 1; m_rready = 1;
        tick();
        m_arvalid = 0; s0_arready = 1;
        tick();
        s0_arready = 0;
        drive_r(1'b0, 1'b1, 32'h1, 2'b00, 1'b0);
        tick();
        drive_r(1'b0, 1'b1, 32'h2, 2'b00, 1'b0);
        #1 check("rst_mid_beat2_visible", 64'(m_rdata), 64'h2);
        reset = 0;
        #1 check("rst_mid_outputs_zero", 64'(|all_out), 64'd0);
        clear_inputs();
        @(negedge clock);
        reset = 1;
        #1 check("rst_mid_arready_low", 64'(m_arready), 64'd0);
        tick();
        check("rst_mid_arready_high", 64'(m_arready), 64'd1);
        do_read(32'h8000_0080, 8'd1, 0, 0, 32'h100, 32'h1);

        // Randomized bursts against the routing model.
        for (int n = 0; n < 40; n++) begin
            logic [31:0] a;
            a = $urandom_range(0, 1) ? (32'h0200_0000 | 32'($urandom_range(0, 16'hffff)))
                                     : $urandom;
            if ($urandom_range(0, 1) == 1)
                do_write(a, 8'($urandom_range(0, 4)), $urandom_range(0, 3), clint_hit(a),
                         $urandom, $urandom);
            else
                do_read(a, 8'($urandom_range(0, 4)), $urandom_range(0, 3), clint_hit(a),
                        $urandom, $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ysyx_23060025_axi_xbar.md
Name: ysyx_23060025_axi_xbar

Overview:
One-master, two-slave AXI4 crossbar between the core-side AXI controller and the memory system.
- Slave 0 is the SoC bus; it is the default target.
- Slave 1 is the CLINT.
- Decodes each read and write address once, at address acceptance, and locks the route until that burst completes.
- The CLINT is read-only: writes to it get a local SLVERR response and are never forwarded.
- Read and write paths are independent FSMs; one outstanding transaction per direction.

Parameters:
- ADDR_LEN, 32, address width.
- DATA_LEN, 32, data width.
- CLINT_BASE, 32'h0200_0000, CLINT region base.
- CLINT_MASK, 32'hffff_0000. An address hits the CLINT when (addr & CLINT_MASK) == CLINT_BASE.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- m_araddr/m_arlen/m_arsize  in  ADDR_LEN/8/3  master read address, burst length, beat size
- m_arvalid  in  1 ; m_arready  out  1  master AR handshake
- m_rdata/m_rresp/m_rlast/m_rvalid  out  DATA_LEN/2/1/1  master R channel
- m_rready  in  1  master R ready
- m_awaddr/m_awlen/m_awsize  in  ADDR_LEN/8/3  master write address
- m_awvalid  in  1 ; m_awready  out  1  master AW handshake
- m_wdata/m_wstrb/m_wlast/m_wvalid  in  DATA_LEN/4/1/1  master W channel
- m_wready  out  1  master W ready
- m_bresp/m_bvalid  out  2/1 ; m_bready  in  1  master B channel
- sN_araddr/sN_arlen/sN_arsize/sN_arvalid  out  ADDR_LEN/8/3/1  slave N AR, N = 0, 1
- sN_arready  in  1  slave N AR ready
- sN_rdata/sN_rresp/sN_rlast/sN_rvalid  in  DATA_LEN/2/1/1  slave N R channel
- sN_rready  out  1  slave N R ready
- s0_awaddr/s0_awlen/s0_awsize/s0_awvalid  out  ADDR_LEN/8/3/1 ; s0_awready  in  1  slave 0 AW
- s0_wdata/s0_wstrb/s0_wlast/s0_wvalid  out  DATA_LEN/4/1/1 ; s0_wready  in  1  slave 0 W
- s0_bresp/s0_bvalid  in  2/1 ; s0_bready  out  1  slave 0 B
- rd_busy, wr_busy  out  1  read / write FSM not idle

Behaviour:
Reset and start-up
- reset low: both FSMs go to IDLE asynchronously; all latched address/len/size/target registers clear to 0; rst_done clears.
- While reset is low, every output is 0.
- rst_done sets on the first clock edge after reset rises. m_arready and m_awready stay 0 until rst_done is 1.
- An in-flight transaction at reset is dropped; no response is generated.

Read FSM: R_IDLE, R_ADDR, R_DATA
- m_arready = rst_done & (rstate == R_IDLE).
- R_IDLE: on m_arvalid & m_arready, latch addr, len, size and target (1 = CLINT hit, else 0); go to R_ADDR.
- R_ADDR: the selected sN_arvalid = 1, driven from the latched registers; they stay stable until sN_arready. Then go to R_DATA. AR reaches the slave exactly 1 cycle after the master handshake.
- R_DATA: selected slave's rdata/rresp/rlast/rvalid pass combinationally to the master; m_rready passes only to the selected sN_rready. On rvalid & rready & rlast, go to R_IDLE.
- The unselected slave's valid and ready outputs are 0 in every state.
- m_r* outputs are 0 outside R_DATA.

Write FSM: W_IDLE, W_ADDR, W_DATA, W_RESP, W_EDATA, W_ERESP
- m_awready = rst_done & (wstate == W_IDLE).
- W_IDLE, on AW handshake: latch the AW fields. Target not CLINT → W_ADDR; CLINT → W_EDATA.
- W_ADDR: s0_awvalid = 1 with the latched fields until s0_awready; then W_DATA.
- W_DATA: W channel passes to slave 0. On wvalid & wready & wlast → W_RESP.
- W_RESP: s0 bvalid/bresp pass to the master; m_bready passes to s0_bready. On handshake → W_IDLE.
- W_EDATA: m_wready = 1, beats are sunk and discarded; on wlast beat → W_ERESP.
- W_ERESP: m_bvalid = 1, m_bresp = 2'b10, until m_bready → W_IDLE.
- m_wready = 0 in W_IDLE and W_ADDR: W data arriving before AW is stalled, not lost.

Concurrency
- Read and write FSMs run concurrently, including to the same slave; there is no ordering between them.
- A new AR/AW is accepted only in IDLE, so the route never changes mid-burst.

Status
- rd_busy = (rstate != R_IDLE); wr_busy = (wstate != W_IDLE).

Test Plan:
1. Read 0x8000_0000, arlen 3, size 2 → s0_arvalid 1 cycle after handshake with araddr 0x8000_0000, arlen 3; s0 beats 0x11/0x22/0x33/0x44 appear on m_rdata with m_rlast on the 4th; s1_* stay 0; m_arready returns 1 the cycle after rlast.
2. Read 0x0200_BFF8, arlen 0 → s1_arvalid asserted, s0_arvalid 0; s1 returns 0x1234_5678 with rlast → m_rdata 0x1234_5678, m_rresp 0.
3. Write 0x0200_4000, awlen 1, wdata 0xA, 0xB → no s0_awvalid; m_wready 1 for both beats; m_bvalid 1 with bresp 2'b10 the cycle after the wlast beat.
4. Same cycle: read to CLINT 0x0200_0000 and write to 0x8000_0100 (wdata 0xDEAD_BEEF, wstrb 4'hF) → both accepted; s1 AR and s0 AW/W/B complete independently; rd_busy and wr_busy both 1 during overlap.
5. s0_arready held low 5 cycles → s0_arvalid held with constant araddr/arlen; m_arready 0 throughout; a second m_arvalid is not accepted until R_IDLE.
6. Assert reset during R_DATA beat 2 of 4 → all outputs 0 asynchronously; after release m_arready 0 for 1 cycle, then 1; a fresh read then completes normally.
